// File: rtl/rv32i_types_pkg.sv
// rv32i_types_pkg: shared types for the instruction/data memory-port arbiter.
package rv32i_types_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    // Which requester owns (or last owned) the shared port.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_grant_t;

    // Fetches always move a full word.
    localparam logic [3:0] FETCH_BYTE_EN = 4'hF;

    // Map a winning requester onto the FSM state that serves it.
    function automatic arb_state_t grant_state(input arb_grant_t gnt);
        return (gnt == GNT_D) ? GRANT_D : GRANT_I;
    endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// arb_priority_sel: picks the winner between fetch and data requests.
// Build option ARB_ROUND_ROBIN_EN: alternate on contention using a last-grant
// flop (reset value GNT_I, so data wins the first contention). Without it,
// data always beats fetch and no state is kept.
module arb_priority_sel
    import rv32i_types_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic       CLK,
    input  logic       nRST,
    input  logic       take,
`endif
    input  logic       i_req,
    input  logic       d_req,
    output logic       any_req,
    output arb_grant_t winner
);

`ifdef ARB_ROUND_ROBIN_EN
    arb_grant_t last_grant;

    // Remember who was granted most recently; updated only when a grant is taken.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant <= GNT_I;
        end else if (take) begin
            last_grant <= winner;
        end
    end

    // On contention, favour whoever was not granted last.
    always_comb begin
        winner = GNT_I;
        if (i_req && d_req) begin
            winner = (last_grant == GNT_D) ? GNT_I : GNT_D;
        end else if (d_req) begin
            winner = GNT_D;
        end
    end
`else
    // Fixed priority: any data request beats a fetch.
    always_comb begin
        winner = d_req ? GNT_D : GNT_I;
    end
`endif

    assign any_req = i_req || d_req;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data load/store. A request seen in IDLE is latched and granted next cycle;
// the grant is held until the shared port reports done (m_busy low).
// Build option ARB_ROUND_ROBIN_EN selects round-robin instead of data-first
// arbitration (handled inside arb_priority_sel).
module mem_port_arbiter
    import rv32i_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    // fetch requester
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [WORD_W-1:0] i_rdata,
    output logic              i_busy,
    // data requester
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    input  logic [3:0]        d_byte_en,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_busy,
    // shared memory port
    output logic              m_ren,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [WORD_W-1:0] m_wdata,
    output logic [3:0]        m_byte_en,
    input  logic [WORD_W-1:0] m_rdata,
    input  logic              m_busy
);

    arb_state_t        state;
    arb_state_t        state_next;
    arb_grant_t        winner;
    logic              any_req;
    logic              d_req;
    logic              take;

    // Request captured at grant time; later requester changes are ignored.
    logic              lat_wen;
    logic [ADDR_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;
    logic [3:0]        lat_byte_en;

    assign d_req = d_ren || d_wen;
    assign take  = (state == IDLE) && any_req;

    arb_priority_sel u_sel (
`ifdef ARB_ROUND_ROBIN_EN
        .CLK     (CLK),
        .nRST    (nRST),
        .take    (take),
`endif
        .i_req   (i_ren),
        .d_req   (d_req),
        .any_req (any_req),
        .winner  (winner)
    );

    // State register; async reset drops any in-flight access.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winner's request when a grant is taken out of IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lat_wen     <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_byte_en <= '0;
        end else if (take) begin
            if (winner == GNT_D) begin
                // Read and write together is treated as a write.
                lat_wen     <= d_wen;
                lat_addr    <= d_addr;
                lat_wdata   <= d_wen ? d_wdata : '0;
                lat_byte_en <= d_byte_en;
            end else begin
                lat_wen     <= 1'b0;
                lat_addr    <= i_addr;
                lat_wdata   <= '0;
                lat_byte_en <= FETCH_BYTE_EN;
            end
        end
    end

    // Next-state and all outputs; the port is quiet in IDLE.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        m_ren      = 1'b0;
        m_wen      = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_byte_en  = '0;
        i_rdata    = '0;
        d_rdata    = '0;
        i_busy     = i_ren;
        d_busy     = d_req;

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = grant_state(winner);
                end
            end
            GRANT_I, GRANT_D: begin
                m_ren     = !lat_wen;
                m_wen     = lat_wen;
                m_addr    = lat_addr;
                m_wdata   = lat_wdata;
                m_byte_en = lat_byte_en;
                if (!m_busy) begin
                    state_next = IDLE;
                    // Completion: hand back data and release the owner's busy.
                    if (state == GRANT_I) begin
                        i_rdata = m_rdata;
                        i_busy  = 1'b0;
                    end else begin
                        d_rdata = m_rdata;
                        d_busy  = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
